// File: rtl/nco_sweep_ctrl_if.sv
// Control/config and NCO/DAC-side signals of the sweep scheduler, bundled as one port.
// master drives configuration and commands; slave is the scheduler itself.
interface nco_sweep_ctrl_if #(
  parameter int PHI_W  = 32,
  parameter int STEP_W = 16
);
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [31:0]       cfg_wdata;
  logic              start;
  logic              abort;
  logic              nco_out_valid;
  logic [PHI_W-1:0]  phi_inc_o;
  logic              nco_clken;
  logic              dac_en;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] step_idx;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start, abort, nco_out_valid,
    input  phi_inc_o, nco_clken, dac_en, busy, done, step_idx
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start, abort, nco_out_valid,
    output phi_inc_o, nco_clken, dac_en, busy, done, step_idx
  );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// NCO frequency sweep/hop scheduler: N points, each a settle window then a dwell window.
// Outputs registered (dac_en = DWELL & nco_out_valid, zero latency); no backpressure. NCO_SWEEP_TRIANGLE_EN adds up/down sweeps.
module nco_sweep_ctrl #(
  parameter int PHI_W      = 32,
  parameter int STEP_W     = 16,
  parameter int DWELL_W    = 24,
  parameter int SETTLE_CYC = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  nco_sweep_ctrl_if.slave bus
);

`ifdef NCO_SWEEP_TRIANGLE_EN
  localparam bit TRI_EN = 1'b1;
`else
  localparam bit TRI_EN = 1'b0;
`endif

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, DWELL, DONE} state_t;

  state_t             state_q;
  logic [PHI_W-1:0]   start_inc_q, step_inc_q;
  logic [STEP_W-1:0]  num_pts_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               loop_q, triangle_q;

  logic [PHI_W-1:0]   sh_start_q, sh_step_q;
  logic [STEP_W-1:0]  sh_last_q;
  logic [DWELL_W-1:0] sh_dwell_q;
  logic               sh_loop_q, sh_tri_q;

  logic [PHI_W-1:0]   phi_q;
  logic [STEP_W-1:0]  idx_q;
  logic               dir_down_q;
  logic [SET_W-1:0]   set_cnt_q;
  logic [DWELL_W-1:0] dwl_cnt_q;
  logic               busy_q, clken_q, done_q;

  logic [PHI_W-1:0]   phi_d;
  logic [STEP_W-1:0]  idx_d;
  logic               dir_down_d;
  logic               sweep_end;

  logic unused_wdata;
  assign unused_wdata = ^bus.cfg_wdata;

  // Config writes are only blocked while a sweep is actually running (DONE accepts them).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_inc_q <= '0;
      step_inc_q  <= '0;
      num_pts_q   <= '0;
      dwell_q     <= '0;
      loop_q      <= 1'b0;
      triangle_q  <= 1'b0;
    end else if (bus.cfg_we && !busy_q) begin
      case (bus.cfg_addr)
        2'd0: start_inc_q <= bus.cfg_wdata[PHI_W-1:0];
        2'd1: step_inc_q  <= bus.cfg_wdata[PHI_W-1:0];
        2'd2: num_pts_q   <= bus.cfg_wdata[STEP_W-1:0];
        default: begin
          dwell_q    <= bus.cfg_wdata[DWELL_W-1:0];
          loop_q     <= bus.cfg_wdata[31];
          triangle_q <= TRI_EN & bus.cfg_wdata[30];
        end
      endcase
    end
  end

  // Next point after a dwell window; a single-point triangle degenerates to sawtooth.
  always_comb begin
    phi_d      = phi_q;
    idx_d      = idx_q;
    dir_down_d = dir_down_q;
    sweep_end  = 1'b0;
    if (sh_tri_q && (sh_last_q != '0)) begin
      if (!dir_down_q) begin
        if (idx_q != sh_last_q) begin
          idx_d = idx_q + 1'b1;
          phi_d = phi_q + sh_step_q;
        end else begin
          dir_down_d = 1'b1;
          idx_d      = idx_q - 1'b1;
          phi_d      = phi_q - sh_step_q;
        end
      end else if (idx_q != '0) begin
        idx_d = idx_q - 1'b1;
        phi_d = phi_q - sh_step_q;
      end else if (sh_loop_q) begin
        dir_down_d = 1'b0;
        idx_d      = idx_q + 1'b1;
        phi_d      = phi_q + sh_step_q;
      end else begin
        sweep_end = 1'b1;
      end
    end else if (idx_q != sh_last_q) begin
      idx_d = idx_q + 1'b1;
      phi_d = phi_q + sh_step_q;
    end else if (sh_loop_q) begin
      idx_d = '0;
      phi_d = sh_start_q;
    end else begin
      sweep_end = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sh_start_q <= '0;
      sh_step_q  <= '0;
      sh_last_q  <= '0;
      sh_dwell_q <= '0;
      sh_loop_q  <= 1'b0;
      sh_tri_q   <= 1'b0;
      phi_q      <= '0;
      idx_q      <= '0;
      dir_down_q <= 1'b0;
      set_cnt_q  <= '0;
      dwl_cnt_q  <= '0;
      busy_q     <= 1'b0;
      clken_q    <= 1'b0;
      done_q     <= 1'b0;
    end else if ((state_q != IDLE) && bus.abort) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      clken_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state_q    <= SETTLE;
            sh_start_q <= start_inc_q;
            sh_step_q  <= step_inc_q;
            sh_last_q  <= (num_pts_q == '0) ? '0 : num_pts_q - 1'b1;
            sh_dwell_q <= (dwell_q == '0) ? '0 : dwell_q - 1'b1;
            sh_loop_q  <= loop_q;
            sh_tri_q   <= triangle_q;
            phi_q      <= start_inc_q;
            idx_q      <= '0;
            dir_down_q <= 1'b0;
            set_cnt_q  <= SET_W'(SETTLE_CYC - 1);
            busy_q     <= 1'b1;
            clken_q    <= 1'b1;
          end
        end
        SETTLE: begin
          if (set_cnt_q == '0) begin
            state_q   <= DWELL;
            dwl_cnt_q <= sh_dwell_q;
          end else begin
            set_cnt_q <= set_cnt_q - 1'b1;
          end
        end
        DWELL: begin
          if (dwl_cnt_q != '0) begin
            dwl_cnt_q <= dwl_cnt_q - 1'b1;
          end else if (sweep_end) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            clken_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q    <= SETTLE;
            phi_q      <= phi_d;
            idx_q      <= idx_d;
            dir_down_q <= dir_down_d;
            set_cnt_q  <= SET_W'(SETTLE_CYC - 1);
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.phi_inc_o = phi_q;
  assign bus.step_idx  = idx_q;
  assign bus.busy      = busy_q;
  assign bus.nco_clken = clken_q;
  assign bus.done      = done_q;
  assign bus.dac_en    = (state_q == DWELL) & bus.nco_out_valid;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed sequences, a table of whole sweeps, then random traffic
// against a timeline model that expands each sweep into its per-cycle expected outputs.
module tb_nco_sweep_ctrl;
  localparam int SETTLE = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nco_sweep_ctrl_if #(.PHI_W(32), .STEP_W(16)) bus ();

  nco_sweep_ctrl #(.PHI_W(32), .STEP_W(16), .DWELL_W(24), .SETTLE_CYC(SETTLE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [63:0] outs();
    return {12'b0, bus.phi_inc_o, bus.step_idx, bus.busy, bus.nco_clken, bus.done, bus.dac_en};
  endfunction

  function automatic logic [63:0] pack(input logic [31:0] phi, input int idx, input bit bsy,
                                       input bit dn, input bit dac);
    return {12'b0, phi, 16'(idx), bsy, bsy, dn, dac};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic cfg_all(input logic [31:0] s, input logic [31:0] st, input logic [31:0] n,
                         input logic [31:0] dw);
    wr(2'd0, s); wr(2'd1, st); wr(2'd2, n); wr(2'd3, dw);
  endtask

  // ---------------- timeline reference model ----------------
  typedef struct { logic [31:0] phi; int idx; bit dw; bit dn; } exp_t;
  exp_t q[$];
  int   rep[$];
  logic [31:0] m_start, m_step, m_phi, s_start, s_step;
  int   m_n, m_dw, m_idx, s_dw;
  bit   m_lp, m_tri, s_loop;

  function automatic void push_point(input int idx);
    exp_t e;
    e.phi = s_start + s_step * idx;
    e.idx = idx; e.dn = 1'b0;
    e.dw = 1'b0; for (int i = 0; i < SETTLE; i++) q.push_back(e);
    e.dw = 1'b1; for (int i = 0; i < s_dw; i++) q.push_back(e);
  endfunction

  function automatic void refill();
    while (s_loop && q.size() < 64) foreach (rep[i]) push_point(rep[i]);
  endfunction

  function automatic void model_start();
    int pts[$];
    int n;
    exp_t e;
    n = (m_n == 0) ? 1 : m_n;
    s_dw = (m_dw == 0) ? 1 : m_dw;
    s_start = m_start; s_step = m_step; s_loop = m_lp;
    for (int i = 0; i < n; i++) pts.push_back(i);
    if (m_tri) for (int i = n - 2; i >= 0; i--) pts.push_back(i);
    foreach (pts[i]) push_point(pts[i]);
    rep.delete();
    if (s_loop) begin
      if (m_tri && n > 1) for (int i = 1; i < pts.size(); i++) rep.push_back(pts[i]);
      else rep = pts;
      refill();
    end else begin
      e = q[q.size()-1];
      e.dw = 1'b0; e.dn = 1'b1;
      q.push_back(e);
    end
  endfunction

  function automatic void model_write(input logic [1:0] a, input logic [31:0] d);
    case (a)
      2'd0: m_start = d;
      2'd1: m_step  = d;
      2'd2: m_n     = int'(d[15:0]);
      default: begin
        m_dw = int'(d[23:0]);
        m_lp = d[31];
`ifdef NCO_SWEEP_TRIANGLE_EN
        m_tri = d[30];
`else
        m_tri = 1'b0;
`endif
      end
    endcase
  endfunction

  typedef struct {
    logic [31:0] s, st, n, dw, last_phi;
    int busy_cyc, last_idx;
  } vec_t;
  vec_t tbl[4];

  logic [31:0] tmp, r_data, p2;
  logic [63:0] expv;
  int cnt, seen, got;
  bit prev_dac, bsy_now;
  logic [31:0] tri_phis[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_wdata = 0;
    bus.start = 0; bus.abort = 0; bus.nco_out_valid = 0;

    tbl[0] = '{32'h47AE147B, 32'h01000000, 32'd3, 32'd4, 32'h49AE147B, 36, 2};
    tbl[1] = '{32'hFFFFFFF0, 32'h00000020, 32'd2, 32'd1, 32'h00000010, 18, 1};
    tbl[2] = '{32'h00001000, 32'hFFFFFFFF, 32'd0, 32'd0, 32'h00001000, 9, 0};
    tbl[3] = '{32'h80000000, 32'h80000000, 32'd4, 32'd2, 32'h00000000, 40, 3};

    repeat (3) @(negedge clk);
    #1;
    chk("in_reset", outs(), 64'd0);
    reset_n = 1'b1;

    // idle after reset while nco_out_valid toggles
    for (int c = 0; c < 100; c++) begin
      bus.nco_out_valid = c[0];
      step();
      chk("idle_after_reset", outs(), 64'd0);
    end

    // three-point sawtooth, cycle by cycle
    cfg_all(32'h47AE147B, 32'h01000000, 32'd3, 32'd4);
    bus.nco_out_valid = 1'b1;
    bus.start = 1'b1;
    for (int c = 1; c <= 37; c++) begin
      step();
      bus.start = 1'b0;
      if (c <= 36)
        expv = pack(32'h47AE147B + (32'((c - 1) / 12) << 24), (c - 1) / 12, 1'b1, 1'b0,
                    ((c - 1) % 12) >= 8);
      else
        expv = pack(32'h49AE147B, 2, 1'b0, 1'b1, 1'b0);
      chk($sformatf("sweep3_cycle%0d", c), outs(), expv);
    end
    step();
    chk("sweep3_done_one_cycle", outs(), pack(32'h49AE147B, 2, 1'b0, 1'b0, 1'b0));

    // table of whole sweeps
    for (int t = 0; t < 4; t++) begin
      cfg_all(tbl[t].s, tbl[t].st, tbl[t].n, tbl[t].dw);
      bus.start = 1'b1;
      cnt = 0; seen = 0;
      for (int k = 0; k < 2000; k++) begin
        step();
        bus.start = 1'b0;
        if (bus.busy) cnt++;
        if (bus.done) begin seen = 1; break; end
      end
      chk($sformatf("tbl%0d_done_seen", t), 64'(seen), 64'd1);
      chk($sformatf("tbl%0d_busy_cycles", t), 64'(cnt), 64'(tbl[t].busy_cyc));
      chk($sformatf("tbl%0d_last_phi", t), 64'(bus.phi_inc_o), 64'(tbl[t].last_phi));
      chk($sformatf("tbl%0d_last_idx", t), 64'(bus.step_idx), 64'(tbl[t].last_idx));
      step();
    end

    // loop with abort in the third point's settle window
    cfg_all(32'h11111111, 32'h00000100, 32'd2, 32'h80000002);
    bus.start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      bus.start = 1'b0;
      if (c <= 22)
        expv = pack((((c - 1) / 10) % 2) ? 32'h11111211 : 32'h11111111, ((c - 1) / 10) % 2,
                    1'b1, 1'b0, ((c - 1) % 10) >= 8);
      else
        expv = pack(32'h11111111, 0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("loop_abort_cycle%0d", c), outs(), expv);
      bus.abort = (c == 22);
    end
    bus.abort = 1'b0;

    // start and abort together in IDLE
    bus.start = 1'b1; bus.abort = 1'b1;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort_idle", 64'({bus.busy, bus.nco_clken}), 64'd0);
    step();
    chk("start_abort_idle_next", 64'({bus.busy, bus.nco_clken}), 64'd0);

    // writes while busy are dropped
    cfg_all(32'h20000000, 32'h00000010, 32'd2, 32'd100);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("busy_write_first_phi", 64'(bus.phi_inc_o), 64'h20000000);
    wr(2'd0, 32'h30000000); wr(2'd1, 32'h5); wr(2'd2, 32'd1);
    got = 0; seen = 0; p2 = 32'h0;
    for (int k = 0; k < 500; k++) begin
      step();
      if (bus.step_idx == 16'd1 && got == 0) begin p2 = bus.phi_inc_o; got = 1; end
      if (bus.done) begin seen = 1; break; end
    end
    chk("busy_write_done_seen", 64'(seen), 64'd1);
    chk("busy_write_second_phi", 64'(p2), 64'h20000010);
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("busy_write_dropped", 64'(bus.phi_inc_o), 64'h20000000);
    bus.abort = 1'b1; step(); bus.abort = 1'b0;
    wr(2'd0, 32'h30000000);
    // write and start in the same cycle: sweep uses the old value
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_wdata = 32'h40000000; bus.start = 1'b1;
    step();
    bus.cfg_we = 1'b0; bus.start = 1'b0;
    chk("write_with_start_old", 64'(bus.phi_inc_o), 64'h30000000);
    bus.abort = 1'b1; step(); bus.abort = 1'b0;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("write_with_start_new", 64'(bus.phi_inc_o), 64'h40000000);

`ifdef NCO_SWEEP_TRIANGLE_EN
    bus.abort = 1'b1; step(); bus.abort = 1'b0;
    cfg_all(32'h00000100, 32'h1, 32'd3, 32'h40000003);
    bus.start = 1'b1;
    prev_dac = 1'b0; seen = 0;
    tri_phis.delete();
    for (int k = 0; k < 500; k++) begin
      step();
      bus.start = 1'b0;
      if (bus.dac_en && !prev_dac) tri_phis.push_back(bus.phi_inc_o);
      prev_dac = bus.dac_en;
      if (bus.done) begin seen = 1; break; end
    end
    chk("tri_done_seen", 64'(seen), 64'd1);
    chk("tri_windows", 64'(tri_phis.size()), 64'd5);
    if (tri_phis.size() == 5) begin
      chk("tri_p0", 64'(tri_phis[0]), 64'h100);
      chk("tri_p1", 64'(tri_phis[1]), 64'h101);
      chk("tri_p2", 64'(tri_phis[2]), 64'h102);
      chk("tri_p3", 64'(tri_phis[3]), 64'h101);
      chk("tri_p4", 64'(tri_phis[4]), 64'h100);
    end
`endif

    // asynchronous reset mid-sweep
    bus.abort = 1'b1; step(); bus.abort = 1'b0;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    repeat (5) step();
    chk("pre_reset_busy", 64'(bus.busy), 64'd1);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", outs() & ~64'd1, 64'd0);
    chk("async_reset_dac", 64'(bus.dac_en), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // random traffic against the model
    m_start = 0; m_step = 0; m_n = 0; m_dw = 0; m_lp = 0; m_tri = 0;
    m_phi = 0; m_idx = 0; q.delete(); rep.delete(); s_loop = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      tmp = $urandom;
      bus.cfg_we   = ($urandom_range(0, 2) == 0);
      bus.cfg_addr = 2'($urandom_range(0, 3));
      case (bus.cfg_addr)
        2'd2:    r_data = (tmp & 32'hFFFF0000) | 32'($urandom_range(0, 4));
        2'd3:    r_data = (tmp & 32'h7F000000) | (($urandom_range(0, 3) == 0) ? 32'h80000000 : 32'h0)
                          | 32'($urandom_range(0, 5));
        default: r_data = tmp;
      endcase
      bus.cfg_wdata     = r_data;
      bus.start         = ($urandom_range(0, 7) == 0);
      bus.abort         = ($urandom_range(0, 99) == 0);
      bus.nco_out_valid = 1'($urandom_range(0, 1));
      #1;
      if (q.size() > 0)
        expv = pack(q[0].phi, q[0].idx, !q[0].dn, q[0].dn, q[0].dw & bus.nco_out_valid);
      else
        expv = pack(m_phi, m_idx, 1'b0, 1'b0, 1'b0);
      chk($sformatf("random_cycle%0d", cyc), outs(), expv);

      bsy_now = (q.size() > 0) && !q[0].dn;
      if (q.size() > 0) begin
        m_phi = q[0].phi; m_idx = q[0].idx;
        if (bus.abort) q.delete();
        else begin void'(q.pop_front()); refill(); end
      end else if (bus.start && !bus.abort) begin
        model_start();
      end
      if (bus.cfg_we && !bsy_now) model_write(bus.cfg_addr, bus.cfg_wdata);
    end
    @(negedge clk);
    bus.cfg_we = 0; bus.start = 0; bus.abort = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
